// File: rtl/bit_scan_dispatcher.sv
// Set-bit enumerator: takes a word over valid/ready and emits the index of each
// set bit, one per cycle, in LSB-first (or MSB-first) order.
module bit_scan_dispatcher #(
  parameter int WIDTH     = 32,
  parameter int IDX_W     = 5,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             empty_done,
  input  logic             abort
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             empty_q, empty_d;
  logic [IDX_W-1:0] idx;
  logic             one_left;

  // Later loop iterations win, so the loop direction picks the scan order.
  always_comb begin
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++)
        if (pending_q[i]) idx = IDX_W'(i);
    end else begin
      for (int i = WIDTH-1; i >= 0; i--)
        if (pending_q[i]) idx = IDX_W'(i);
    end
  end

  assign one_left = (|pending_q) && ((pending_q & (pending_q - WIDTH'(1))) == '0);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    empty_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (|in_word) begin
            pending_d = in_word;
            state_d   = BUSY;
          end else begin
            empty_d = 1'b1;
          end
        end
      end
      BUSY: begin
        // A transfer coinciding with abort still completes; nothing to undo.
        if (abort) begin
          pending_d = '0;
          state_d   = IDLE;
        end else if (out_ready) begin
          pending_d = pending_q & ~(WIDTH'(1) << idx);
          if (one_left) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      empty_q   <= empty_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == BUSY);
  assign out_index  = out_valid ? idx : '0;
  assign out_last   = out_valid & one_left;
  assign empty_done = empty_q;

endmodule

// File: tb/tb_bit_scan_dispatcher.sv
// Bench for bit_scan_dispatcher: an LSB-first and an MSB-first instance share
// stimulus; a scoreboard per instance predicts every delivered index.
module tb_bit_scan_dispatcher;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, out_ready, abort;
  logic [31:0] in_word;
  logic        in_ready, out_valid, out_last, empty_done;
  logic [4:0]  out_index;
  logic        m_in_ready, m_out_valid, m_out_last, m_empty_done;
  logic [4:0]  m_out_index;

  always #5 clock = ~clock;

  bit_scan_dispatcher #(.WIDTH(32), .IDX_W(5), .MSB_FIRST(1'b0)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_last(out_last), .empty_done(empty_done), .abort(abort));

  bit_scan_dispatcher #(.WIDTH(32), .IDX_W(5), .MSB_FIRST(1'b1)) dut_m (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_word(in_word), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_index(m_out_index), .out_last(m_out_last), .empty_done(m_empty_done), .abort(abort));

  typedef struct { logic [4:0] idx; logic last; } exp_t;
  typedef struct { logic [31:0] word; int cycles; } vec_t;

  exp_t q_l[$];
  exp_t q_m[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Push the first ntake indices of each scan order (ntake<0 means all of them).
  function automatic void push_word(input logic [31:0] w, input int ntake);
    int   cnt = $countones(w);
    int   k;
    exp_t e;
    k = 0;
    for (int i = 0; i < 32; i++)
      if (w[i]) begin
        e.idx = 5'(i); e.last = (k == cnt-1);
        if (ntake < 0 || k < ntake) q_l.push_back(e);
        k++;
      end
    k = 0;
    for (int i = 31; i >= 0; i--)
      if (w[i]) begin
        e.idx = 5'(i); e.last = (k == cnt-1);
        if (ntake < 0 || k < ntake) q_m.push_back(e);
        k++;
      end
  endfunction

  // Monitor: pops scoreboards on transfers and checks hold-during-stall.
  logic       stall_l = 1'b0, stall_m = 1'b0;
  logic [6:0] prev_l, prev_m;
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      stall_l = 1'b0; stall_m = 1'b0;
    end else begin
      chk("rdy_match", m_in_ready, in_ready);
      if (stall_l) chk("lsb_hold", {out_valid, out_last, out_index}, prev_l);
      if (stall_m) chk("msb_hold", {m_out_valid, m_out_last, m_out_index}, prev_m);
      if (empty_done || out_valid) chk("empty_excl", empty_done && out_valid, 0);
      if (out_valid && out_ready) begin
        chk("lsb_expected", q_l.size() != 0, 1);
        if (q_l.size() != 0) begin
          e = q_l.pop_front();
          chk("lsb_idx", out_index, e.idx);
          chk("lsb_last", out_last, e.last);
        end
      end
      if (m_out_valid && out_ready) begin
        chk("msb_expected", q_m.size() != 0, 1);
        if (q_m.size() != 0) begin
          e = q_m.pop_front();
          chk("msb_idx", m_out_index, e.idx);
          chk("msb_last", m_out_last, e.last);
        end
      end
      stall_l = out_valid && !out_ready;
      stall_m = m_out_valid && !out_ready;
      prev_l  = {out_valid, out_last, out_index};
      prev_m  = {m_out_valid, m_out_last, m_out_index};
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic send(input logic [31:0] w, input int ntake, output int waited);
    waited = 0;
    in_valid = 1'b1; in_word = w;
    while (!in_ready && waited < 100) begin tick(); waited++; end
    chk("accept_ready", in_ready, 1);
    push_word(w, ntake);
    tick();
    in_valid = 1'b0;
    chk("first_latency", out_valid, (w != 0));
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!(in_ready && m_in_ready) && n < 100) begin tick(); n++; end
  endtask

  vec_t vecs[6];

  initial begin
    int n, w;
    vecs[0] = '{32'h0000_8421, 4};
    vecs[1] = '{32'h0000_0000, 0};
    vecs[2] = '{32'hFFFF_FFFF, 32};
    vecs[3] = '{32'h8000_0000, 1};
    vecs[4] = '{32'h0000_0001, 1};
    vecs[5] = '{32'hA5A5_0000, 8};

    reset_n = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b1; abort = 1'b0;
    repeat (2) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_empty_done", empty_done, 0);
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      send(vecs[v].word, -1, w);
      chk("empty_pulse", empty_done, (vecs[v].word == 0));
      chk("empty_pulse_m", m_empty_done, (vecs[v].word == 0));
      wait_idle(n);
      chk("busy_cycles", n, vecs[v].cycles);
      tick();
      chk("empty_pulse_off", empty_done, 0);
    end

    // Stall: index 0, then 31 held through two stall cycles.
    send(32'h8000_0001, -1, w);
    tick();
    out_ready = 1'b0;
    tick(); tick();
    chk("stall_idx", out_index, 31);
    chk("stall_last", out_last, 1);
    chk("stall_idx_m", m_out_index, 0);
    out_ready = 1'b1;
    tick();
    chk("stall_done", in_ready, 1);
    tick();

    // Abort on the second transfer: remaining bits vanish.
    send(32'h0000_00F0, 2, w);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", in_ready, 1);
    chk("abort_no_valid", out_valid, 0);
    repeat (3) tick();

    // Abort while idle is ignored and the load still happens.
    abort = 1'b1;
    send(32'h0000_0003, -1, w);
    abort = 1'b0;
    chk("idle_abort_busy", out_valid, 1);
    // Held word is not taken while busy; accepted after 2 transfers + bubble.
    send(32'h0000_0005, -1, w);
    chk("hold_wait", w, 2);
    wait_idle(n);
    chk("b2b_cycles", n, 2);
    tick();

    // Async reset mid-scan.
    send(32'h0000_0F00, 1, w);
    tick();
    #1 reset_n = 1'b0;
    #1;
    chk("areset_valid", out_valid, 0);
    chk("areset_ready", in_ready, 1);
    chk("areset_valid_m", m_out_valid, 0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("post_reset_quiet", out_valid, 0);
    send(32'h0000_0102, -1, w);
    wait_idle(n);
    chk("post_reset_cycles", n, 2);
    repeat (2) tick();

    chk("lsb_q_drained", q_l.size(), 0);
    chk("msb_q_drained", q_m.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
